// File: rtl/perm_iter.sv
// Iterated bit permutation: out[k] = in[4k mod (W-1)] (or its inverse), applied
// in_rounds times, one round per cycle. Define PERM_ITER_FASTPATH_EN to allow
// a new accept in the same cycle as the output handshake.
module perm_iter #(
  parameter int W  = 64,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:W-1]  in_data,
  input  logic          in_inv,
  input  logic [CW-1:0] in_rounds,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:W-1]  out_data,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [0:W-1]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inv_q, inv_d;
  logic          live_q;
  logic          accept;
  logic [0:W-1]  fwd_p, inv_p;

  // Bit W-1 is a fixed point of both permutations.
  for (genvar k = 0; k < W - 1; k++) begin : g_perm
    assign fwd_p[k] = data_q[(4 * k) % (W - 1)];
    assign inv_p[k] = data_q[(k * (W / 4)) % (W - 1)];
  end
  assign fwd_p[W-1] = data_q[W-1];
  assign inv_p[W-1] = data_q[W-1];

  // live_q holds in_ready low until the first edge after reset release.
`ifdef PERM_ITER_FASTPATH_EN
  assign in_ready = live_q & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
`else
  assign in_ready = live_q & (state_q == S_IDLE);
`endif

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign out_data  = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        data_d = inv_q ? inv_p : fwd_p;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      data_d  = in_data;
      inv_d   = in_inv;
      cnt_d   = in_rounds;
      state_d = (in_rounds != '0) ? S_BUSY : S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      live_q  <= 1'b1;
    end
  end

endmodule
